// File: rtl/irq_controller_if.sv
// Request/acknowledge bus between the interrupt controller (slave) and the processor side (master).
interface irq_controller_if #(
  parameter int unsigned NUM_CH = 8
);
  localparam int unsigned ID_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] irq_in;
  logic              mask_we;
  logic [NUM_CH-1:0] mask_wdata;
  logic              irq_ack;
  logic              irq_eoi;
  logic              IRQ;
  logic [ID_W-1:0]   irq_id;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] mask;

  modport master (
    output irq_in, mask_we, mask_wdata, irq_ack, irq_eoi,
    input  IRQ, irq_id, pending, mask
  );

  modport slave (
    input  irq_in, mask_we, mask_wdata, irq_ack, irq_eoi,
    output IRQ, irq_id, pending, mask
  );
endinterface

// File: rtl/irq_controller.sv
// Fixed-priority interrupt controller: one request in flight, IDLE -> ASSERT -> SERVICE handshake.
// Optional macro IRQ_EDGE_DETECT_EN turns EDGE_CH channels into rising-edge triggered inputs.
module irq_controller #(
  parameter int unsigned       NUM_CH  = 8,
  parameter int unsigned       ID_W    = $clog2(NUM_CH),
  parameter logic [NUM_CH-1:0] EDGE_CH = '0
) (
  input  logic         clk,
  input  logic         RESET_N,
  irq_controller_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_irq;
  logic [ID_W-1:0]   r_id;
  logic [NUM_CH-1:0] r_pending;
  logic [NUM_CH-1:0] r_mask;

  logic [NUM_CH-1:0] w_rise;
  logic [NUM_CH-1:0] w_set;
  logic [NUM_CH-1:0] w_clr;
  logic [NUM_CH-1:0] w_req;
  logic [NUM_CH-1:0] w_pending_nxt;
  logic [ID_W-1:0]   w_first;
  logic              w_any;

`ifdef IRQ_EDGE_DETECT_EN
  localparam logic [NUM_CH-1:0] LP_EDGE = EDGE_CH;

  logic [NUM_CH-1:0] r_hist;

  // Previous-cycle view of irq_in for rising-edge detection
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_hist <= '0;
    end else begin
      r_hist <= bus.irq_in;
    end
  end

  assign w_rise = bus.irq_in & ~r_hist;
`else
  // Edge detection compiled out: every channel behaves as level-triggered
  localparam logic [NUM_CH-1:0] LP_EDGE = EDGE_CH & {NUM_CH{1'b0}};

  assign w_rise = '0;
`endif

  assign w_set         = (bus.irq_in & ~LP_EDGE) | (w_rise & LP_EDGE);
  assign w_clr         = (r_state == ST_ASSERT && bus.irq_ack) ? (NUM_CH'(1) << r_id) : '0;
  assign w_pending_nxt = w_set | (r_pending & ~w_clr);
  assign w_req         = r_pending & r_mask;
  assign w_any         = |w_req;

  // Lowest set index wins; scanning downward leaves the smallest index last
  always_comb begin
    w_first = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_first = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= ST_IDLE;
      r_irq     <= 1'b0;
      r_id      <= '0;
      r_pending <= '0;
      r_mask    <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      if (bus.mask_we) begin
        r_mask <= bus.mask_wdata;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_id    <= w_first;
            r_irq   <= 1'b1;
            r_state <= ST_ASSERT;
          end
        end
        ST_ASSERT: begin
          if (bus.irq_ack) begin
            r_irq   <= 1'b0;
            r_state <= ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (bus.irq_eoi) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_irq   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.IRQ     = r_irq;
  assign bus.irq_id  = r_id;
  assign bus.pending = r_pending;
  assign bus.mask    = r_mask;

endmodule

// File: tb/tb_irq_controller.sv
// Directed and randomized checks of irq_controller against a cycle-level behavioural model.
module tb_irq_controller;

  localparam int unsigned       NUM_CH    = 8;
  localparam logic [NUM_CH-1:0] EDGE_MASK = 8'h01;
`ifdef IRQ_EDGE_DETECT_EN
  localparam bit EDGE_ON = 1'b1;
`else
  localparam bit EDGE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic RESET_N;
  int   n_checks = 0;
  int   n_pass   = 0;

  irq_controller_if #(.NUM_CH(NUM_CH)) bus ();
  irq_controller_if #(.NUM_CH(32))     bus32 ();

  irq_controller #(.NUM_CH(NUM_CH), .EDGE_CH(EDGE_MASK)) dut (
    .clk(clk), .RESET_N(RESET_N), .bus(bus)
  );

  irq_controller #(.NUM_CH(32), .EDGE_CH(32'h0)) dut32 (
    .clk(clk), .RESET_N(RESET_N), .bus(bus32)
  );

  always #5 clk = ~clk;

  // Reference model: what the controller should be showing to the processor
  logic [NUM_CH-1:0] m_pending;
  logic [NUM_CH-1:0] m_mask;
  logic [NUM_CH-1:0] m_prev;
  bit                m_present;
  bit                m_serve;
  int                m_id;
  int                m_rises;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pending = '0;
    m_mask    = '0;
    m_prev    = '0;
    m_present = 1'b0;
    m_serve   = 1'b0;
    m_id      = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_step();
    logic [NUM_CH-1:0] trig;
    logic [NUM_CH-1:0] clr;
    int first;
    first = -1;
    clr   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (EDGE_ON && EDGE_MASK[i]) trig[i] = bus.irq_in[i] && !m_prev[i];
      else                         trig[i] = bus.irq_in[i];
      if (first < 0 && m_pending[i] && m_mask[i]) first = i;
    end
    if (m_present) begin
      if (bus.irq_ack) begin
        clr[m_id] = 1'b1;
        m_present = 1'b0;
        m_serve   = 1'b1;
      end
    end else if (m_serve) begin
      if (bus.irq_eoi) m_serve = 1'b0;
    end else if (first >= 0) begin
      m_present = 1'b1;
      m_id      = first;
      m_rises++;
    end
    m_pending = trig | (m_pending & ~clr);
    if (bus.mask_we) m_mask = bus.mask_wdata;
    m_prev = bus.irq_in;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_irq"},     32'(bus.IRQ),     32'(m_present));
    chk({tag, "_id"},      32'(bus.irq_id),  32'(m_id));
    chk({tag, "_pending"}, 32'(bus.pending), 32'(m_pending));
    chk({tag, "_mask"},    32'(bus.mask),    32'(m_mask));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic clear_inputs();
    bus.irq_in     = '0;
    bus.mask_we    = 1'b0;
    bus.mask_wdata = '0;
    bus.irq_ack    = 1'b0;
    bus.irq_eoi    = 1'b0;
  endtask

  // Mid-cycle reset pulse: outputs must clear before any clock edge
  task automatic do_reset(input string tag);
    RESET_N = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    clear_inputs();
    @(negedge clk);
    RESET_N = 1'b1;
  endtask

  initial begin
    bit prev_irq;
    int dut_rises;

    clear_inputs();
    bus32.irq_in     = '0;
    bus32.mask_we    = 1'b0;
    bus32.mask_wdata = '0;
    bus32.irq_ack    = 1'b0;
    bus32.irq_eoi    = 1'b0;
    m_rises          = 0;

    // Reset held with all requests high, released with mask cleared
    RESET_N    = 1'b0;
    bus.irq_in = 8'hFF;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("rst_hold");
    @(negedge clk);
    RESET_N = 1'b1;
    tick("first_edge");
    chk("first_edge_pending_ff", 32'(bus.pending), 32'h0000_00FF);
    tick("masked_a");
    tick("masked_b");
    chk("masked_no_irq", 32'(bus.IRQ), 32'd0);

    // Two simultaneous requests: lower index first, then the other after eoi
    do_reset("rst_pulse_a");
    bus.mask_we    = 1'b1;
    bus.mask_wdata = 8'hFF;
    tick("mask_all");
    bus.mask_we    = 1'b0;
    bus.irq_in     = 8'h24;
    tick("req_2_5_set");
    chk("latency_irq_low", 32'(bus.IRQ), 32'd0);
    bus.irq_in = 8'h00;
    tick("req_2_present");
    chk("present_irq", 32'(bus.IRQ), 32'd1);
    chk("present_id2", 32'(bus.irq_id), 32'd2);
    bus.irq_eoi = 1'b1;
    tick("eoi_in_assert");
    bus.irq_eoi = 1'b0;
    chk("eoi_ignored_irq", 32'(bus.IRQ), 32'd1);
    chk("eoi_ignored_id", 32'(bus.irq_id), 32'd2);
    bus.irq_ack = 1'b1;
    tick("ack_2");
    chk("ack_2_pending", 32'(bus.pending), 32'h0000_0020);
    chk("ack_2_irq_low", 32'(bus.IRQ), 32'd0);
    tick("ack_in_service");
    bus.irq_ack = 1'b0;
    bus.irq_eoi = 1'b1;
    tick("eoi_2");
    bus.irq_eoi = 1'b0;
    tick("req_5_present");
    chk("present_id5", 32'(bus.irq_id), 32'd5);
    bus.irq_ack = 1'b1;
    tick("ack_5");
    bus.irq_ack = 1'b0;
    bus.irq_eoi = 1'b1;
    tick("eoi_5");
    bus.irq_eoi = 1'b0;
    bus.irq_ack = 1'b1;
    tick("ack_in_idle");
    bus.irq_ack = 1'b0;
    chk("ack_idle_irq", 32'(bus.IRQ), 32'd0);
    chk("ack_idle_id", 32'(bus.irq_id), 32'd5);

    // Level request held through its ack: set beats clear
    bus.irq_in = 8'h08;
    tick("lvl3_set");
    tick("lvl3_present");
    bus.irq_ack = 1'b1;
    tick("lvl3_ack");
    chk("set_wins_pending", 32'(bus.pending), 32'h0000_0008);
    bus.irq_ack = 1'b0;
    bus.irq_in  = 8'h00;
    bus.irq_eoi = 1'b1;
    tick("lvl3_eoi");
    bus.irq_eoi = 1'b0;
    tick("lvl3_again");
    chk("lvl3_again_irq", 32'(bus.IRQ), 32'd1);

    // Reset in the middle of ASSERT discards the request
    do_reset("rst_in_assert");
    chk("rst_in_assert_irq_now", 32'(bus.IRQ), 32'd0);
    repeat (3) tick("post_rst_quiet");
    chk("post_rst_no_irq", 32'(bus.IRQ), 32'd0);

    // Mask write on the arbitration edge: old mask still rules that edge
    bus.irq_in = 8'h10;
    tick("mw_pending");
    bus.irq_in     = 8'h00;
    bus.mask_we    = 1'b1;
    bus.mask_wdata = 8'hFF;
    tick("mw_edge");
    chk("mw_old_mask_irq", 32'(bus.IRQ), 32'd0);
    bus.mask_we = 1'b0;
    tick("mw_next");
    chk("mw_new_mask_id4", 32'(bus.irq_id), 32'd4);
    bus.irq_ack = 1'b1;
    tick("mw_ack");
    bus.irq_ack = 1'b0;
    bus.irq_eoi = 1'b1;
    tick("mw_eoi");
    bus.irq_eoi = 1'b0;

    // Channel 0 held high ten cycles, processor acks/eois every time
    do_reset("rst_edge");
    bus.mask_we    = 1'b1;
    bus.mask_wdata = 8'hFF;
    tick("edge_mask");
    bus.mask_we = 1'b0;
    m_rises     = 0;
    dut_rises   = 0;
    for (int c = 0; c < 24; c++) begin
      bus.irq_in  = (c < 10) ? 8'h01 : 8'h00;
      bus.irq_ack = m_present;
      bus.irq_eoi = m_serve;
      prev_irq    = bus.IRQ;
      tick("edge_run");
      if (!prev_irq && bus.IRQ) dut_rises++;
    end
    clear_inputs();
    chk("irq_assert_count", 32'(dut_rises), 32'(m_rises));
`ifdef IRQ_EDGE_DETECT_EN
    chk("edge_single_irq", 32'(dut_rises), 32'd1);
`endif
    repeat (3) tick("edge_drain");

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      if (c == 200) do_reset("rst_random");
      bus.irq_in     = NUM_CH'($urandom & $urandom & $urandom);
      bus.irq_ack    = ($urandom_range(0, 2) == 0);
      bus.irq_eoi    = ($urandom_range(0, 2) == 0);
      bus.mask_we    = ($urandom_range(0, 7) == 0);
      bus.mask_wdata = NUM_CH'($urandom);
      tick("rand");
    end
    clear_inputs();

    // 32-channel instance: only the top channel requests
    do_reset("rst_w32");
    bus32.mask_we    = 1'b1;
    bus32.mask_wdata = 32'hFFFF_FFFF;
    bus32.irq_in     = 32'h8000_0000;
    tick("w32_a");
    bus32.mask_we = 1'b0;
    tick("w32_b");
    tick("w32_c");
    chk("w32_irq", 32'(bus32.IRQ), 32'd1);
    chk("w32_id31", 32'(bus32.irq_id), 32'd31);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter NUM_CH, default 8, number of request channels, legal range 2..32.
REQ-002 Parameter ID_W, default $clog2(NUM_CH), irq_id width, derived and not overridden.
REQ-003 Parameter EDGE_CH, default 0, NUM_CH-bit mask selecting edge-triggered channels (bit=1 edge, bit=0 level).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 RESET_N  in  1  asynchronous, active-low reset.
REQ-006 irq_in  in  NUM_CH  raw requests, synchronous to clk.
REQ-007 mask_we  in  1  mask write strobe.
REQ-008 mask_wdata  in  NUM_CH  new enable mask, 1 = channel enabled.
REQ-009 irq_ack  in  1  processor accepts the presented interrupt.
REQ-010 irq_eoi  in  1  processor signals end of interrupt service.
REQ-011 IRQ  out  1  interrupt request to processor.
REQ-012 irq_id  out  ID_W  index of the presented channel.
REQ-013 pending  out  NUM_CH  registered pending vector.
REQ-014 mask  out  NUM_CH  current mask register.

Function
REQ-015 Request condition, level channel: irq_in[i]=1 at a clock edge sets pending[i].
REQ-016 FSM states IDLE, ASSERT, SERVICE; one request in flight, no nesting.
REQ-017 IDLE: if (pending & mask) != 0, latch lowest set index into irq_id, drive IRQ=1, go to ASSERT on that edge.
REQ-018 Latency: irq_in sampled high at edge k -> pending high after edge k -> IRQ high after edge k+1.
REQ-019 ASSERT: IRQ=1 and irq_id held stable until irq_ack=1; masking the channel in ASSERT does not withdraw IRQ.
REQ-020 ASSERT with irq_ack=1: clear pending[irq_id], IRQ=0 after that edge, go to SERVICE.
REQ-021 SERVICE: IRQ=0, irq_id held; irq_eoi=1 returns FSM to IDLE; next arbitration on the following edge.
REQ-022 irq_ack outside ASSERT and irq_eoi outside SERVICE are ignored.
REQ-023 A level channel still high after its ack re-sets pending on the next edge.
REQ-024 A set condition and an ack-clear for the same channel on the same edge: set wins, pending stays 1.
REQ-025 mask_we=1 updates mask on the edge; arbitration on that same edge uses the old mask.
REQ-026 Priority is fixed: index 0 highest; no starvation protection.

Reset
REQ-027 RESET_N=0 immediately forces IRQ=0, irq_id=0, pending=0, mask=0, edge history=0, FSM=IDLE, regardless of clk.
REQ-028 Reset asserted mid-ASSERT or mid-SERVICE discards the in-flight request; no IRQ after release until a new request condition.
REQ-029 First state update occurs on the first rising clk edge with RESET_N=1.

Configuration
REQ-030 Macro IRQ_EDGE_DETECT_EN defined: per-channel irq_in history register added; channel with EDGE_CH[i]=1 sets pending[i] only on 0->1 of irq_in[i] between consecutive edges.
REQ-031 Macro IRQ_EDGE_DETECT_EN undefined: no history register, EDGE_CH ignored, all channels level-triggered.

Verification
REQ-032 RESET_N=0 with irq_in=8'hFF; release with mask=0 -> IRQ stays 0, pending=8'hFF after first edge.
REQ-033 mask=8'hFF, irq_in[5] and irq_in[2] rise on same edge -> IRQ=1 two edges later, irq_id=2; ack -> pending[2]=0, IRQ=0; eoi -> irq_id=5 presented next arbitration.
REQ-034 RESET_N pulsed low while in ASSERT -> IRQ=0 and pending=0 immediately, no IRQ after release with irq_in=0.
REQ-035 IRQ_EDGE_DETECT_EN defined, EDGE_CH=8'h01, irq_in[0] held high 10 cycles, ack+eoi each -> exactly one IRQ assertion.
REQ-036 irq_ack pulsed in IDLE and irq_eoi pulsed in ASSERT -> no state change, IRQ and irq_id unchanged.
REQ-037 NUM_CH=32, mask=32'hFFFFFFFF, only irq_in[31] high -> IRQ=1, irq_id=5'd31.
